// File: rtl/sram_cfg_writer_if.sv
// SRAM pin bundle between the settings writer and the top-level SRAM mux.
// The master drives address/control/data; the slave returns read data.
interface sram_cfg_writer_if;
  logic        own;
  logic [20:0] sramA;
  logic        sramWe;
  logic        sramDoEn;
  logic [7:0]  sramDo;
  logic [7:0]  sramDi;

  modport master (
    output own,
    output sramA,
    output sramWe,
    output sramDoEn,
    output sramDo,
    input  sramDi
  );

  modport slave (
    input  own,
    input  sramA,
    input  sramWe,
    input  sramDoEn,
    input  sramDo,
    output sramDi
  );
endinterface

// File: rtl/sram_cfg_writer.sv
// Writes the scandoubler settings byte to SRAM between Z80 memory cycles,
// verifies it by read-back and retries a bounded number of times.
module sram_cfg_writer #(
  parameter logic [20:0] ADDR        = 21'h08FD5,
  parameter logic [5:0]  FILL        = 6'h00,
  parameter int          SETUP_CYC   = 1,
  parameter int          WE_CYC      = 2,
  parameter int          RETRIES     = 2,
  parameter int          BUS_TIMEOUT = 255
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ce,
  input  logic             req,
  input  logic [1:0]       cfg,
  input  logic             mreq,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             hold,
  sram_cfg_writer_if.master sram
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_BUS,
    S_SETUP,
    S_WRITE,
    S_HOLD,
    S_VERIFY,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYC - 1);
  localparam logic [7:0] WE_LAST    = 8'(WE_CYC - 1);
  localparam logic [7:0] TMO_LAST   = 8'(BUS_TIMEOUT - 1);
  localparam logic [2:0] RETRY_MAX  = 3'(RETRIES);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  retry_q, retry_d;
  logic [1:0]  cfg_q, cfg_d;
  logic        err_q, err_d;
  logic        own_q, own_d;
  logic        we_q, we_d;
  logic        doen_q, doen_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [20:0] a_q, a_d;
  logic [7:0]  do_q, do_d;
  logic [7:0]  wr_byte;

  assign wr_byte = {FILL, cfg_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    cfg_d   = cfg_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (ce && req) begin
          cfg_d   = cfg;
          err_d   = 1'b0;
          retry_d = 3'd0;
          cnt_d   = 8'd0;
          state_d = S_WAIT_BUS;
        end
      end
      S_WAIT_BUS: begin
        if (ce) begin
          if (mreq) begin
            cnt_d   = 8'd0;
            state_d = S_SETUP;
          end else if (cnt_q == TMO_LAST) begin
            cnt_d   = 8'd0;
            state_d = S_ERR;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_SETUP: begin
        if (ce) begin
          if (cnt_q == SETUP_LAST) begin
            cnt_d   = 8'd0;
            state_d = S_WRITE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_WRITE: begin
        if (ce) begin
          if (cnt_q == WE_LAST) begin
            cnt_d   = 8'd0;
            state_d = S_HOLD;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_HOLD: begin
        if (ce) begin
          cnt_d   = 8'd0;
          state_d = S_VERIFY;
        end
      end
      S_VERIFY: begin
        // first tick lets the bus turn around; read on the second
        if (ce) begin
          if (cnt_q == 8'd0) begin
            cnt_d = 8'd1;
          end else begin
            cnt_d = 8'd0;
            if (sram.sramDi == wr_byte) begin
              state_d = S_DONE;
            end else if (retry_q < RETRY_MAX) begin
              retry_d = retry_q + 3'd1;
              state_d = S_SETUP;
            end else begin
              state_d = S_ERR;
            end
          end
        end
      end
      // done must stay exactly one clock wide regardless of ce
      S_DONE: state_d = S_IDLE;
      S_ERR: begin
        if (ce) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_ERR) err_d = 1'b1;
  end

  // pins are registered from the next state so they never glitch
  always_comb begin
    own_d  = state_d inside {S_SETUP, S_WRITE, S_HOLD, S_VERIFY};
    doen_d = state_d inside {S_SETUP, S_WRITE, S_HOLD};
    we_d   = (state_d != S_WRITE);
    busy_d = state_d inside {S_WAIT_BUS, S_SETUP, S_WRITE,
                             S_HOLD, S_VERIFY};
    done_d = (state_d == S_DONE);
    a_d    = own_d ? ADDR : 21'd0;
    do_d   = doen_d ? {FILL, cfg_d} : 8'd0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      retry_q <= 3'd0;
      cfg_q   <= 2'd0;
      err_q   <= 1'b0;
      own_q   <= 1'b0;
      we_q    <= 1'b1;
      doen_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      a_q     <= 21'd0;
      do_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      cfg_q   <= cfg_d;
      err_q   <= err_d;
      own_q   <= own_d;
      we_q    <= we_d;
      doen_q  <= doen_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      a_q     <= a_d;
      do_q    <= do_d;
    end
  end

  assign busy          = busy_q;
  assign hold          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign sram.own      = own_q;
  assign sram.sramA    = a_q;
  assign sram.sramWe   = we_q;
  assign sram.sramDoEn = doen_q;
  assign sram.sramDo   = do_q;

endmodule

// File: tb/tb_sram_cfg_writer.sv
// Bench for sram_cfg_writer: table of write/verify operations against an
// SRAM byte model, plus reset-during-write and reset-state sequences.
module tb_sram_cfg_writer;

  logic       clock = 1'b0;
  logic       reset;
  logic       ce;
  logic       req;
  logic [1:0] cfg;
  logic       mreq;
  logic       busy, done, err, hold;

  sram_cfg_writer_if sram ();

  sram_cfg_writer dut (
    .clock (clock),
    .reset (reset),
    .ce    (ce),
    .req   (req),
    .cfg   (cfg),
    .mreq  (mreq),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .hold  (hold),
    .sram  (sram)
  );

  always #5 clock = ~clock;

  // SRAM byte model; read-back is forced bad for the first bad_n attempts
  logic [7:0] mem = 8'h00;
  int         att = 0;
  int         bad_n = 0;

  assign sram.sramDi = (att <= bad_n) ? 8'hFF : mem;

  always @(posedge clock)
    if (sram.own && sram.sramDoEn && !sram.sramWe) mem <= sram.sramDo;

  typedef struct {
    logic [1:0] cfg;
    int         bad;
    int         md;
    int         div;
    bit         spam;
    int         exp_tick;
    int         exp_pulses;
    bit         exp_err;
    logic [7:0] exp_mem;
  } vec_t;

  typedef struct {
    int         tick;
    int         pulses;
    bit         err;
    logic [7:0] mem_b;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  function automatic void chk(input string nm,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  task automatic idle_ticks(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clock);
      req = 1'b0;
      ce  = 1'b1;
      mreq = 1'b1;
    end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int   n;
    int   pulses;
    int   clk_i;
    bit   prev_low;
    bit   fin;
    exp_t e;
    idle_ticks(2);
    att   = 0;
    bad_n = v.bad;
    @(negedge clock);
    req  = 1'b1;
    cfg  = v.cfg;
    ce   = 1'b1;
    mreq = (v.md == 0);
    e = '{v.exp_tick, v.exp_pulses, v.exp_err, v.exp_mem};
    sb.push_back(e);
    @(posedge clock);
    #1;
    n = 1;
    chk($sformatf("v%0d_accept_busy", id), 32'(busy), 32'd1);
    chk($sformatf("v%0d_accept_errclr", id), 32'(err), 32'd0);
    pulses   = 0;
    prev_low = 1'b0;
    fin      = 1'b0;
    clk_i    = 0;
    while (!fin && clk_i < 3000) begin
      @(negedge clock);
      clk_i++;
      req  = v.spam && (n == 3);
      cfg  = ~v.cfg;
      ce   = ((clk_i % v.div) == 0);
      mreq = (n >= v.md + 1);
      @(posedge clock);
      #1;
      if (ce) n++;
      if (v.md > 0 && v.md < 100 && n <= v.md) begin
        chk($sformatf("v%0d_wait_own", id), 32'(sram.own), 32'd0);
        chk($sformatf("v%0d_wait_hold", id), 32'(hold), 32'd1);
      end
      if (!sram.sramWe && !prev_low) begin
        pulses++;
        att++;
        chk($sformatf("v%0d_we_owndoen", id),
            32'({sram.own, sram.sramDoEn}), 32'd3);
        chk($sformatf("v%0d_we_addr", id),
            32'(sram.sramA), 32'h08FD5);
        chk($sformatf("v%0d_we_data", id),
            32'(sram.sramDo), 32'({6'h00, v.cfg}));
      end
      prev_low = !sram.sramWe;
      if (done || err) fin = 1'b1;
    end
    if (!fin) chk($sformatf("v%0d_no_end", id), 32'd0, 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk($sformatf("v%0d_tick", id), 32'(n), 32'(e.tick));
      chk($sformatf("v%0d_pulses", id), 32'(pulses), 32'(e.pulses));
      chk($sformatf("v%0d_err", id), 32'(err), 32'(e.err));
      chk($sformatf("v%0d_done", id), 32'(done), 32'(!e.err));
      chk($sformatf("v%0d_mem", id), 32'(mem), 32'(e.mem_b));
      chk($sformatf("v%0d_released", id),
          32'({busy, hold, sram.own}), 32'd0);
    end
    @(negedge clock);
    ce  = 1'b0;
    req = 1'b0;
    @(posedge clock);
    #1;
    chk($sformatf("v%0d_done_width", id), 32'(done), 32'd0);
    chk($sformatf("v%0d_err_sticky", id), 32'(err), 32'(v.exp_err));
  endtask

  vec_t tbl[9];
  vec_t rv;

  initial begin
    int guard;
    tbl[0] = '{2'b10, 0, 0,    1, 1'b0, 8,   1, 1'b0, 8'h02};
    tbl[1] = '{2'b01, 1, 0,    1, 1'b0, 14,  2, 1'b0, 8'h01};
    tbl[2] = '{2'b11, 2, 0,    1, 1'b0, 20,  3, 1'b0, 8'h03};
    tbl[3] = '{2'b00, 9, 0,    1, 1'b0, 20,  3, 1'b1, 8'h00};
    tbl[4] = '{2'b10, 0, 20,   1, 1'b0, 28,  1, 1'b0, 8'h02};
    tbl[5] = '{2'b10, 0, 0,    4, 1'b1, 8,   1, 1'b0, 8'h02};
    tbl[6] = '{2'b01, 1, 0,    4, 1'b0, 14,  2, 1'b0, 8'h01};
    tbl[7] = '{2'b01, 0, 1000, 1, 1'b0, 256, 0, 1'b1, 8'h01};
    tbl[8] = '{2'b11, 0, 0,    1, 1'b0, 8,   1, 1'b0, 8'h03};

    reset = 1'b1;
    ce    = 1'b1;
    req   = 1'b0;
    cfg   = 2'b00;
    mreq  = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_hold", 32'(hold), 32'd0);
    chk("rst_own", 32'(sram.own), 32'd0);
    chk("rst_we", 32'(sram.sramWe), 32'd1);
    chk("rst_doen", 32'(sram.sramDoEn), 32'd0);
    chk("rst_addr", 32'(sram.sramA), 32'd0);
    chk("rst_do", 32'(sram.sramDo), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(tbl[i], i);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    // reset while WE is low must drop the bus on the next clock
    idle_ticks(2);
    att   = 0;
    bad_n = 0;
    @(negedge clock);
    req = 1'b1;
    cfg = 2'b10;
    guard = 0;
    @(posedge clock);
    #1;
    while (sram.sramWe && guard < 20) begin
      @(negedge clock);
      req = 1'b0;
      @(posedge clock);
      #1;
      guard++;
    end
    chk("rstw_reached_write", 32'(sram.sramWe), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("rstw_we", 32'(sram.sramWe), 32'd1);
    chk("rstw_doen", 32'(sram.sramDoEn), 32'd0);
    chk("rstw_own", 32'(sram.own), 32'd0);
    chk("rstw_hold", 32'(hold), 32'd0);
    chk("rstw_busy", 32'(busy), 32'd0);
    chk("rstw_done", 32'(done), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    rv = '{2'b01, 0, 0, 1, 1'b0, 8, 1, 1'b0, 8'h01};
    run_vec(rv, 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
